tower_slot_ledger: RTL

- Writer and owner of the 8-bit tower-occupancy vector, fi_used_array, that the score block reads.
- Accepts player place and sell requests for one of 8 tower slots.
- Checks affordability against the current score and slot state.
- Commits at most one bit change per transaction, then holds a settle window. This guarantees the score block sees every placement (-30) or removal (+20) as a separate monotonic change and never misses one.

---
 rtl/tower_slot_ledger.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tower_slot_ledger.sv
// Tower-occupancy ledger: arbitrates place/sell requests and owns fi_used_array.
// Optional `define SCORE_CONFIRM_EN: SETTLE also waits for a score change, 64-cycle timeout.
module tower_slot_ledger #(
  parameter int TOWER_COST    = 30,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        place_req,
  input  logic        sell_req,
  input  logic [2:0]  slot,
  input  logic [31:0] score,
  output logic [7:0]  fi_used_array,
  output logic        busy,
  output logic        grant,
  output logic        deny,
  output logic [1:0]  deny_code
`ifdef SCORE_CONFIRM_EN
  ,
  output logic        confirm_timeout
`endif
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  localparam logic signed [31:0] COST_S      = TOWER_COST;
  localparam logic [7:0]         SETTLE_LOAD = 8'(SETTLE_CYCLES);

  logic [1:0]         state;
  logic [2:0]         slot_q;
  logic               is_place;
  logic signed [31:0] score_snap;
  logic [7:0]         settle_cnt;
`ifdef SCORE_CONFIRM_EN
  logic [5:0]         settle_age;
`endif

  always_comb begin
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= ST_IDLE;
      slot_q        <= '0;
      is_place      <= 1'b0;
      score_snap    <= '0;
      settle_cnt    <= '0;
      fi_used_array <= '0;
      grant         <= 1'b0;
      deny          <= 1'b0;
      deny_code     <= '0;
`ifdef SCORE_CONFIRM_EN
      settle_age      <= '0;
      confirm_timeout <= 1'b0;
`endif
    end else begin
      grant     <= 1'b0;
      deny      <= 1'b0;
      deny_code <= '0;
`ifdef SCORE_CONFIRM_EN
      confirm_timeout <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (place_req || sell_req) begin
            slot_q     <= slot;
            is_place   <= place_req;
            score_snap <= score;
            state      <= ST_CHECK;
          end
        end
        // The bit update and grant are registered on the CHECK edge so both
        // become visible during the COMMIT cycle.
        ST_CHECK: begin
          if (is_place) begin
            if (fi_used_array[slot_q]) begin
              deny      <= 1'b1;
              deny_code <= 2'b01;
              state     <= ST_IDLE;
            end else if (score_snap < COST_S) begin
              deny      <= 1'b1;
              deny_code <= 2'b10;
              state     <= ST_IDLE;
            end else begin
              fi_used_array[slot_q] <= 1'b1;
              grant                 <= 1'b1;
              state                 <= ST_COMMIT;
            end
          end else begin
            if (!fi_used_array[slot_q]) begin
              deny      <= 1'b1;
              deny_code <= 2'b11;
              state     <= ST_IDLE;
            end else begin
              fi_used_array[slot_q] <= 1'b0;
              grant                 <= 1'b1;
              state                 <= ST_COMMIT;
            end
          end
        end
        ST_COMMIT: begin
          settle_cnt <= SETTLE_LOAD;
          state      <= ST_SETTLE;
`ifdef SCORE_CONFIRM_EN
          settle_age <= '0;
`endif
        end
        ST_SETTLE: begin
`ifdef SCORE_CONFIRM_EN
          settle_age <= settle_age + 6'd1;
          if (settle_cnt != 8'd0) begin
            settle_cnt <= settle_cnt - 8'd1;
          end
          // Minimum hold elapses when the counter passes 1; then wait for the score to move.
          if ((settle_cnt <= 8'd1) && (score != score_snap)) begin
            settle_cnt <= '0;
            state      <= ST_IDLE;
          end else if (settle_age == 6'd63) begin
            settle_cnt      <= '0;
            confirm_timeout <= 1'b1;
            state           <= ST_IDLE;
          end
`else
          if (settle_cnt <= 8'd1) begin
            settle_cnt <= '0;
            state      <= ST_IDLE;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
